// File: rtl/md_pkg.sv
// Shared encodings and FSM states for the multiply/divide sequencer.
// Latency: none (definitions only).
// Backpressure: not applicable.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_PREP = 2'd1,
    MD_RUN  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_t;

  // Upper op bit selects divide; the lower bit marks the unsigned variants.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is registered.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               div_mode_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);

  logic [WIDTH:0]   top;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   sum;

  // Divide: shift left then trial-subtract the divisor from the upper half.
  // Multiply: add the multiplicand when the multiplier LSB is set, then shift right.
  always_comb begin
    top     = '0;
    rem     = '0;
    sum     = '0;
    acc_o   = acc_i;
    q_bit_o = 1'b0;
    if (div_mode_i) begin
      top     = acc_i[2*WIDTH-1:WIDTH-1];
      q_bit_o = (top >= {1'b0, operand_i});
      // When the trial succeeds the true difference is below the divisor, so W bits suffice.
      rem     = q_bit_o ? (top[WIDTH-1:0] - operand_i) : top[WIDTH-1:0];
      acc_o   = {rem, acc_i[WIDTH-2:0], 1'b0};
    end else begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; optional MULDIV_FAST_MUL_EN gives single-cycle multiply.
// Latency: WIDTH+2 cycles busy per op (1 cycle for fast multiply); HI/LO written on the last busy edge.
// Backpressure: stall_md asks the hazard unit to hold D while busy; start_e is ignored when not idle.
module muldiv_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  input  logic             md_use_d,
  output logic             stall_md,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q_bit;
  logic [2*WIDTH-1:0] fast_prod;
  logic               sgn_e, a_neg, b_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign sgn_e = md_is_signed(op_e);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  // Sign-extending both operands to 2*WIDTH makes a single truncated product correct for MULT and MULTU.
  assign fast_prod = {{WIDTH{sgn_e & src_a_e[WIDTH-1]}}, src_a_e} *
                     {{WIDTH{sgn_e & src_b_e[WIDTH-1]}}, src_b_e};
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_prod = '0;
`endif

  // Multiply keeps the multiplier in the low half and adds the multiplicand; divide shifts the dividend and subtracts the divisor.
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i      (acc_q),
    .operand_i  (md_is_div(op_q) ? b_q : a_q),
    .div_mode_i (md_is_div(op_q)),
    .acc_o      (step_acc),
    .q_bit_o    (step_q_bit)
  );

  // Next-state and datapath updates; everything holds unless the current state acts on it.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    a_neg    = 1'b0;
    b_neg    = 1'b0;
    prod_fix = '0;
    quo_fix  = '0;
    rem_fix  = '0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_e) begin
          a_neg   = sgn_e & src_a_e[WIDTH-1];
          b_neg   = sgn_e & src_b_e[WIDTH-1];
          op_d    = op_e;
          // Magnitude of -2^(W-1) is 2^(W-1) as an unsigned value, so no overflow handling is needed.
          a_d     = a_neg ? -src_a_e : src_a_e;
          b_d     = b_neg ? -src_b_e : src_b_e;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          state_d = MD_PREP;
          if (FAST_MUL && !md_is_div(op_e)) begin
            hi_d    = fast_prod[2*WIDTH-1:WIDTH];
            lo_d    = fast_prod[WIDTH-1:0];
            state_d = MD_FIX;
          end
        end
      end
      MD_PREP: begin
        acc_d   = {{WIDTH{1'b0}}, (md_is_div(op_q) ? a_q : b_q)};
        cnt_d   = '0;
        state_d = MD_RUN;
      end
      MD_RUN: begin
        acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (md_is_div(op_q)) begin
          quo_fix = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          rem_fix = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          // Zero divisor leaves the dividend in the remainder; the quotient is forced to all ones.
          lo_d    = (b_q == '0) ? '1 : quo_fix;
          hi_d    = rem_fix;
          dz_d    = dz_q | (b_q == '0);
        end else if (!FAST_MUL) begin
          prod_fix = neg_q_q ? -acc_q : acc_q;
          hi_d     = prod_fix[2*WIDTH-1:WIDTH];
          lo_d     = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and architectural registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != MD_IDLE);
  assign stall_md = busy & md_use_d;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the pipelined MIPS core: accepts MULT/MULTU/DIV/DIVU from the execute stage, runs an iterative shift-add / restoring-divide datapath, and owns the architectural HI/LO registers. It sits beside the ALU in E and feeds a stall request into the hazard unit. The hazard unit ORs this request into `stall_f`, `stall_d` and `flush_e` whenever a decode-stage instruction needs HI/LO, or the unit itself, while an operation is in flight.

## Interface

Parameters:
- `WIDTH`, 32, operand width; HI/LO are each WIDTH bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_e`  in  1  E-stage mult/div instruction valid; sampled only in IDLE.
- `op_e`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a_e`  in  WIDTH  multiplicand / dividend (forwarded rs).
- `src_b_e`  in  WIDTH  multiplier / divisor (forwarded rt).
- `md_use_d`  in  1  D-stage instruction is MFHI/MFLO/MULT/MULTU/DIV/DIVU.
- `stall_md`  out  1  stall request to hazard unit.
- `busy`  out  1  operation in flight (state != IDLE).
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `div_zero`  out  1  sticky: set when any DIV/DIVU has divisor 0; cleared only by reset.

## Operation

- FSM states: IDLE, PREP, RUN, FIX.
- IDLE + `start_e`:
  - latch the op.
  - For signed ops, latch the absolute values of the operands and record the result signs. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); product sign = sign(a) XOR sign(b).
  - Go to PREP.
- PREP: clear the 2·WIDTH accumulator and the iteration counter; go to RUN.
- RUN: exactly WIDTH iterations, one per cycle.
  - Multiply: conditional add of the multiplicand, then right shift.
  - Divide: shift left, trial subtract, set quotient bit when the result is non-negative.
  - Counter is a $clog2(WIDTH)-bit up-counter; on the iteration with count == WIDTH-1, go to FIX.
- FIX: apply two's-complement sign correction and write the results, then go to IDLE.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Arithmetic rules:
  - Unsigned ops use the raw operands.
  - abs(-2^(W-1)) is taken as an unsigned W-bit value with no overflow. This gives DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - Divisor 0: LO = all ones, HI = dividend (signed or unsigned as given), `div_zero` set. The divisor-0 case still takes the full latency.
- `stall_md` = `busy` && `md_use_d`. It is purely combinational, with no registered delay.
- `start_e` while busy cannot occur, because the stall holds the instruction in D. If it does occur anyway, it is ignored.
- HI/LO change only in FIX. There is no MTHI/MTLO path.

## Timing

- Reset values: state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `stall_md` = 0, `div_zero` = 0, counter = 0.
- Let E0 be the edge that samples `start_e`. Then:
  - PREP after E0.
  - RUN after E1.
  - Iterations at E2..E(WIDTH+1).
  - FIX after E(WIDTH+1).
  - HI/LO written at E(WIDTH+2).
  - `busy` falls after E(WIDTH+2).
- For WIDTH = 32: `busy` is high for 34 cycles, and MFHI in D stalls until the cycle after HI is written.
- A new `start_e` is accepted in the first IDLE cycle, giving back-to-back operations with no bubble.
- Reset mid-operation: returns to IDLE immediately and asynchronously. HI/LO are zeroed and the partial result is discarded.

## Configuration

- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU compute the full product with a single-cycle multiplier at E0 and write HI/LO at E0.
  - The FSM goes IDLE → FIX → IDLE, so `busy` is high one cycle.
  - Divide is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: all ops are iterative as above. No hardware multiplier is inferred.

## Structure

- Shared package `md_pkg`:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - state typedef `md_state_t`.
  - default `MD_WIDTH` = 32.
- Sub-module `muldiv_step`: combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator and quotient bit.
  - The sequencer holds the FSM, counter, sign logic and HI/LO.

## Test plan

- MULT 0xFFFFFFFE × 0x00000003 → after 34 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. `stall_md` high while `md_use_d` = 1 for cycles 1..34.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV -7 / 2 → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 100, `div_zero` = 1 and remaining 1 after the next op.
- Back-to-back: MULTU 3×4 then DIVU 13/4 with `start_e` asserted the first IDLE cycle → HI/LO = 0/12, then HI = 1, LO = 3. No idle gap.
- `rst_n` pulsed low at RUN iteration 10 → `busy` = 0, `hi` = `lo` = 0 immediately. A subsequent MULTU 2×2 yields LO = 4.
